// File: rtl/avg8_seq_ctrl.sv
// ---------------------------------------------------------------------------
// avg8_seq_ctrl : serial NSAMP-sample accumulate-and-shift averager with
//                 valid/ready input and output ports.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module avg8_seq_ctrl #(
  parameter int DATAW = 16,
  parameter int NSAMP = 8,
  parameter int SAW   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic [SAW-1:0]             sa,
  input  logic [DATAW-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATAW-1:0]           avg,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic [$clog2(NSAMP):0]     count
);

  localparam int ACCW = DATAW + $clog2(NSAMP);
  localparam int CW   = $clog2(NSAMP) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic [CW-1:0]     count_q, count_d;
  logic [SAW-1:0]    sa_q, sa_d;
  logic [DATAW-1:0]  avg_q, avg_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;

  logic              accept_w;
  logic [ACCW-1:0]   sum_w;
  logic [ACCW-1:0]   shifted_w;

  assign accept_w  = in_valid & in_ready_q;
  assign sum_w     = acc_q + ACCW'(in_data);
  // Shift amounts at or beyond the accumulator width flush the result to zero.
  assign shifted_w = (32'(sa_q) >= ACCW) ? '0 : (sum_w >> sa_q);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    sa_d        = sa_q;
    avg_d       = avg_q;
    out_valid_d = out_valid_q;

    if (clr) begin
      state_d     = IDLE;
      acc_d       = '0;
      count_d     = '0;
      avg_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_w) begin
            acc_d   = ACCW'(in_data);
            count_d = CW'(1);
            sa_d    = sa;
            state_d = ACC;
          end
        end
        ACC: begin
          if (accept_w) begin
            acc_d   = sum_w;
            count_d = count_q + CW'(1);
            if (count_q == CW'(NSAMP - 1)) begin
              avg_d       = shifted_w[DATAW-1:0];
              out_valid_d = 1'b1;
              state_d     = OUT;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            count_d     = '0;
            acc_d       = '0;
            state_d     = IDLE;
          end
        end
        default: begin
          state_d     = IDLE;
          acc_d       = '0;
          count_d     = '0;
          out_valid_d = 1'b0;
        end
      endcase
    end

    // Registered ready: looks ahead at the state being entered.
    in_ready_d = ((state_d == IDLE) || (state_d == ACC)) && !clr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      count_q     <= '0;
      sa_q        <= '0;
      avg_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      sa_q        <= sa_d;
      avg_q       <= avg_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign avg       = avg_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_avg8_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_avg8_seq_ctrl : table-driven bench for avg8_seq_ctrl with directed
//                    batch vectors plus abort/reset sequences.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_avg8_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        clr;
  logic [7:0]  sa;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] avg;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [3:0]  count;

  int n_vec;
  int n_bad;

  avg8_seq_ctrl #(.DATAW(16), .NSAMP(8), .SAW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .sa        (sa),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .avg       (avg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic [7:0]        sa_first;
    logic [7:0]        sa_after;
    bit                gap;
    int                bp;
    logic [7:0][15:0]  smp;
    logic [15:0]       exp_avg;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0][15:0] fill(input logic [15:0] v);
    logic [7:0][15:0] r;
    for (int i = 0; i < 8; i++) r[i] = v;
    return r;
  endfunction

  function automatic logic [7:0][15:0] ramp();
    logic [7:0][15:0] r;
    for (int i = 0; i < 8; i++) r[i] = 16'(i + 1);
    return r;
  endfunction

  task automatic run_batch(input vec_t v);
    out_ready = (v.bp == 0);
    for (int i = 0; i < 8; i++) begin
      chk({v.name, "/in_ready_pre"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = v.smp[i];
      sa       = (i == 0) ? v.sa_first : v.sa_after;
      tick();
      in_valid = 1'b0;
      in_data  = 16'h5A5A;
      chk({v.name, "/count"}, 32'(count), 32'(i + 1));
      if (v.gap && i < 7) begin
        tick();
        chk({v.name, "/count_gap_hold"}, 32'(count), 32'(i + 1));
      end
    end
    chk({v.name, "/out_valid"}, 32'(out_valid), 32'd1);
    chk({v.name, "/avg"}, 32'(avg), 32'(v.exp_avg));
    chk({v.name, "/in_ready_out"}, 32'(in_ready), 32'd0);
    chk({v.name, "/busy_out"}, 32'(busy), 32'd1);
    for (int b = 0; b < v.bp; b++) begin
      in_valid = b[0] ? 1'b0 : 1'b1;
      in_data  = 16'hDEAD;
      tick();
      chk({v.name, "/bp_out_valid"}, 32'(out_valid), 32'd1);
      chk({v.name, "/bp_avg"}, 32'(avg), 32'(v.exp_avg));
      chk({v.name, "/bp_in_ready"}, 32'(in_ready), 32'd0);
      chk({v.name, "/bp_count"}, 32'(count), 32'd8);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk({v.name, "/rel_out_valid"}, 32'(out_valid), 32'd0);
    chk({v.name, "/rel_count"}, 32'(count), 32'd0);
    chk({v.name, "/rel_in_ready"}, 32'(in_ready), 32'd1);
    chk({v.name, "/rel_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "/in_ready"}, 32'(in_ready), 32'd0);
    chk({nm, "/busy"}, 32'(busy), 32'd0);
    chk({nm, "/count"}, 32'(count), 32'd0);
    chk({nm, "/out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "/avg"}, 32'(avg), 32'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b0;
    clr       = 1'b0;
    sa        = 8'd0;
    in_data   = 16'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{"ones_sa3",      8'd3,  8'd3,  1'b0, 0, fill(16'd1),     16'd1};
    vecs[1] = '{"ffff_sa3",      8'd3,  8'd3,  1'b0, 0, fill(16'hFFFF),  16'hFFFF};
    vecs[2] = '{"ffff_sa0",      8'd0,  8'd0,  1'b0, 0, fill(16'hFFFF),  16'hFFF8};
    vecs[3] = '{"ffff_sa20",     8'd20, 8'd20, 1'b0, 0, fill(16'hFFFF),  16'h0000};
    vecs[4] = '{"ffff_sa18",     8'd18, 8'd18, 1'b0, 0, fill(16'hFFFF),  16'h0001};
    vecs[5] = '{"ramp_bp5",      8'd1,  8'd1,  1'b0, 5, ramp(),          16'd18};
    vecs[6] = '{"sa_change",     8'd2,  8'd0,  1'b0, 0, fill(16'd4),     16'd8};
    vecs[7] = '{"gapped",        8'd1,  8'd1,  1'b1, 0, fill(16'd2),     16'd8};
    vecs[8] = '{"h8000_sa19",    8'd19, 8'd19, 1'b0, 0, fill(16'h8000),  16'h0000};
    vecs[9] = '{"h8000_sa18",    8'd18, 8'd18, 1'b0, 0, fill(16'h8000),  16'h0001};

    repeat (2) tick();
    chk_reset_vals("reset");
    rst = 1'b1;
    #1;
    chk("rel/in_ready_before_edge", 32'(in_ready), 32'd0);
    tick();
    chk("rel/in_ready_after_edge", 32'(in_ready), 32'd1);

    for (int v = 0; v < 10; v++) run_batch(vecs[v]);

    // Abort after four samples; the sample presented with clr is dropped.
    sa = 8'd3;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'd100;
      tick();
    end
    chk("clr/count_pre", 32'(count), 32'd4);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr/busy", 32'(busy), 32'd0);
    chk("clr/count", 32'(count), 32'd0);
    chk("clr/out_valid", 32'(out_valid), 32'd0);
    chk("clr/in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("clr/in_ready_back", 32'(in_ready), 32'd1);
    chk("clr/out_valid_still", 32'(out_valid), 32'd0);
    chk("clr/count_still", 32'(count), 32'd0);
    run_batch('{"post_clr", 8'd3, 8'd3, 1'b0, 0, fill(16'd10), 16'd10});

    // Asynchronous reset mid-batch discards the partial sum.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'd7;
      sa       = 8'd0;
      tick();
    end
    in_valid = 1'b0;
    chk("rst_mid/count_pre", 32'(count), 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid/in_ready_before_edge", 32'(in_ready), 32'd0);
    tick();
    chk("rst_mid/in_ready_after_edge", 32'(in_ready), 32'd1);
    run_batch('{"post_rst", 8'd0, 8'd0, 1'b0, 0, fill(16'd1), 16'd8});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
